// File: rtl/instr_load_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : instr_load_scheduler_pkg
// Purpose  : Shared types for the instruction register load scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package instr_load_scheduler_pkg;

    typedef enum logic [3:0] {
        ZERO  = 4'd0,
        PASSA = 4'd1,
        PASSB = 4'd2,
        ADD   = 4'd3,
        SUB   = 4'd4,
        MULT  = 4'd5,
        DIV   = 4'd6,
        MOD   = 4'd7
    } opcode_t;

    typedef logic signed [31:0] operand_t;
    typedef logic [4:0]         address_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
    } instruction_t;

    localparam int INSTR_DEPTH = 2**$bits(address_t);

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/instr_load_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : instr_load_scheduler_if
// Purpose  : Requester, register-load and consumer signals of the scheduler.
//            grant_cnt exists only when INSTR_SCHED_STATS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface instr_load_scheduler_if
    import instr_load_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ-1:0]             req_ready;
    opcode_t                        req_opcode    [NUM_REQ];
    operand_t                       req_operand_a [NUM_REQ];
    operand_t                       req_operand_b [NUM_REQ];
    logic                           flush;
    logic                           load_en;
    opcode_t                        opcode;
    operand_t                       operand_a;
    operand_t                       operand_b;
    address_t                       write_pointer;
    address_t                       read_pointer;
    logic                           rd_req;
    logic                           rd_valid;
    logic [$clog2(INSTR_DEPTH):0]   count;
    logic                           full;
    logic [$clog2(NUM_REQ)-1:0]     grant_id;
`ifdef INSTR_SCHED_STATS_EN
    logic [15:0]                    grant_cnt [NUM_REQ];
`endif

    modport master (
        output req_valid, req_opcode, req_operand_a, req_operand_b, flush, rd_req,
        input  req_ready, load_en, opcode, operand_a, operand_b, write_pointer,
               read_pointer, rd_valid, count, full, grant_id
`ifdef INSTR_SCHED_STATS_EN
        , input grant_cnt
`endif
    );

    modport slave (
        input  req_valid, req_opcode, req_operand_a, req_operand_b, flush, rd_req,
        output req_ready, load_en, opcode, operand_a, operand_b, write_pointer,
               read_pointer, rd_valid, count, full, grant_id
`ifdef INSTR_SCHED_STATS_EN
        , output grant_cnt
`endif
    );

endinterface
`default_nettype wire

// File: rtl/instr_load_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin arbiter; search starts at i_pointer.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  wire logic [N-1:0]  i_req,
    input  wire logic [IW-1:0] i_pointer,
    input  wire logic          i_enable,
    output logic      [N-1:0]  o_grant,
    output logic      [IW-1:0] o_idx,
    output logic               o_valid
);
    localparam int c_SW = IW + 1;

    logic [c_SW-1:0] w_pos;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_pos   = '0;
        for (int k = 0; k < N; k++) begin
            // One extra bit holds pointer+k before the modulo-N wrap
            w_pos = {1'b0, i_pointer} + c_SW'(k);
            if (w_pos >= c_SW'(N)) begin
                w_pos = w_pos - c_SW'(N);
            end
            if (i_enable && !o_valid && i_req[w_pos[IW-1:0]]) begin
                o_valid                 = 1'b1;
                o_grant[w_pos[IW-1:0]]  = 1'b1;
                o_idx                   = w_pos[IW-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/instr_load_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : instr_load_scheduler
// Purpose  : Round-robin loader and circular-queue sequencer for the 32-entry
//            instruction register. Optional macro: INSTR_SCHED_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module instr_load_scheduler
    import instr_load_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DEPTH   = INSTR_DEPTH
) (
    input  wire logic               clk,
    input  wire logic               reset,
    instr_load_scheduler_if.slave   bus
);
    localparam int c_IW = $clog2(NUM_REQ);
    localparam int c_CW = $clog2(DEPTH) + 1;

    sched_state_t       r_state;
    logic               r_load_en;
    instruction_t       r_instr;
    address_t           r_wptr;
    address_t           r_rptr;
    logic [c_CW-1:0]    r_count;
    logic [c_IW-1:0]    r_grant_id;
    logic [c_IW-1:0]    r_rr_ptr;

    logic [c_CW-1:0]    w_occ;
    logic               w_can_load;
    logic [NUM_REQ-1:0] w_grant;
    logic [c_IW-1:0]    w_idx;
    logic               w_xfer;
    logic               w_rd_valid;
    logic               w_pop;

    // The in-flight write counts toward occupancy so a pop cannot free a slot early
    assign w_occ      = r_count + c_CW'(r_load_en);
    assign w_can_load = (r_state == RUN) && (w_occ < c_CW'(DEPTH));
    assign w_rd_valid = (r_state == RUN) && (r_count != '0);
    assign w_pop      = bus.rd_req && w_rd_valid;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (c_IW)
    ) u_rr_arbiter (
        .i_req     (bus.req_valid),
        .i_pointer (r_rr_ptr),
        .i_enable  (w_can_load),
        .o_grant   (w_grant),
        .o_idx     (w_idx),
        .o_valid   (w_xfer)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= RUN;
            r_load_en  <= 1'b0;
            r_instr    <= '{opc: ZERO, op_a: '0, op_b: '0};
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_grant_id <= '0;
            r_rr_ptr   <= '0;
        end else begin
            case (r_state)
                RUN: begin
                    r_load_en <= w_xfer;
                    if (w_xfer) begin
                        r_instr    <= '{opc:  bus.req_opcode[w_idx],
                                        op_a: bus.req_operand_a[w_idx],
                                        op_b: bus.req_operand_b[w_idx]};
                        r_grant_id <= w_idx;
                        r_rr_ptr   <= (w_idx == c_IW'(NUM_REQ - 1)) ? '0 : w_idx + c_IW'(1);
                    end
                    if (r_load_en) begin
                        r_wptr <= r_wptr + address_t'(1);
                    end
                    if (w_pop) begin
                        r_rptr <= r_rptr + address_t'(1);
                    end
                    r_count <= r_count + c_CW'(r_load_en) - c_CW'(w_pop);
                    if (bus.flush) begin
                        r_state <= FLUSH;
                    end
                end
                FLUSH: begin
                    // A pending load still strobes the register this cycle; the queue is then emptied
                    r_load_en <= 1'b0;
                    r_wptr    <= '0;
                    r_rptr    <= '0;
                    r_count   <= '0;
                    r_state   <= RUN;
                end
                default: begin
                    r_state <= RUN;
                end
            endcase
        end
    end

`ifdef INSTR_SCHED_STATS_EN
    logic [15:0] r_grant_cnt [NUM_REQ];

    always_ff @(posedge clk) begin
        if (reset || (r_state == FLUSH)) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                r_grant_cnt[i] <= '0;
            end
        end else if (w_xfer && (r_grant_cnt[w_idx] != 16'hFFFF)) begin
            r_grant_cnt[w_idx] <= r_grant_cnt[w_idx] + 16'd1;
        end
    end

    assign bus.grant_cnt = r_grant_cnt;
`endif

    assign bus.req_ready     = w_grant;
    assign bus.load_en       = r_load_en;
    assign bus.opcode        = r_instr.opc;
    assign bus.operand_a     = r_instr.op_a;
    assign bus.operand_b     = r_instr.op_b;
    assign bus.write_pointer = r_wptr;
    assign bus.read_pointer  = r_rptr;
    assign bus.rd_valid      = w_rd_valid;
    assign bus.count         = r_count;
    assign bus.full          = (w_occ == c_CW'(DEPTH));
    assign bus.grant_id      = r_grant_id;

endmodule
`default_nettype wire
